// File: rtl/change_dispense_ctrl_pkg.sv
// Shared types and constants for the change dispenser: FSM states,
// the coin select encoding used by the deposit and eject paths, and coin values.
package change_dispense_ctrl_pkg;

  localparam int DEFAULT_AMT_W = 5;
  localparam int DEFAULT_CNT_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLAN,
    ST_PAY_REQ,
    ST_PAY_WAIT,
    ST_DONE,
    ST_FAIL
  } state_t;

  typedef enum logic [1:0] {
    COIN_ONE  = 2'd0,
    COIN_TWO  = 2'd1,
    COIN_FIVE = 2'd2,
    COIN_TEN  = 2'd3
  } coin_t;

  localparam logic [3:0] COIN_VALUE [4] = '{4'd1, 4'd2, 4'd5, 4'd10};

  function automatic logic [3:0] coin_value(input logic [1:0] sel);
    return COIN_VALUE[sel];
  endfunction

endpackage

// File: rtl/change_dispense_ctrl_if.sv
// Coin ejector handshake: the controller holds eject_req/eject_coin
// until the ejector answers with eject_ack.
interface change_dispense_ctrl_if;

  logic       eject_req;
  logic [1:0] eject_coin;
  logic       eject_ack;

  modport master (output eject_req, output eject_coin, input eject_ack);
  modport slave  (input eject_req, input eject_coin, output eject_ack);

endinterface

// File: rtl/change_dispense_ctrl_greedy_coin_pick.sv
// Combinational greedy selector: largest coin that fits the amount and is in stock.
module greedy_coin_pick
  import change_dispense_ctrl_pkg::*;
#(
  parameter int AMT_W = DEFAULT_AMT_W,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic [AMT_W-1:0] amount,
  input  logic [CNT_W-1:0] cnt_one,
  input  logic [CNT_W-1:0] cnt_two,
  input  logic [CNT_W-1:0] cnt_five,
  input  logic [CNT_W-1:0] cnt_ten,
  output logic             found,
  output logic [1:0]       coin_sel,
  output logic [AMT_W-1:0] coin_val
);

  always_comb begin
    found    = 1'b0;
    coin_sel = COIN_ONE;
    coin_val = '0;
    if (cnt_ten != '0 && amount >= AMT_W'(coin_value(COIN_TEN))) begin
      found    = 1'b1;
      coin_sel = COIN_TEN;
    end else if (cnt_five != '0 && amount >= AMT_W'(coin_value(COIN_FIVE))) begin
      found    = 1'b1;
      coin_sel = COIN_FIVE;
    end else if (cnt_two != '0 && amount >= AMT_W'(coin_value(COIN_TWO))) begin
      found    = 1'b1;
      coin_sel = COIN_TWO;
    end else if (cnt_one != '0 && amount >= AMT_W'(coin_value(COIN_ONE))) begin
      found    = 1'b1;
      coin_sel = COIN_ONE;
    end
    if (found) coin_val = AMT_W'(coin_value(coin_sel));
  end

endmodule

// File: rtl/change_dispense_ctrl.sv
// Change payout sequencer: dry-runs a greedy payout on a shadow inventory,
// then ejects coins one at a time only if the full amount can be paid.
module change_dispense_ctrl
  import change_dispense_ctrl_pkg::*;
#(
  parameter int AMT_W = DEFAULT_AMT_W,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [AMT_W-1:0]       change_amt,
  input  logic                   coin_in_valid,
  input  logic [1:0]             coin_in_sel,
  input  logic                   load_inv,
  input  logic [CNT_W-1:0]       inv_one,
  input  logic [CNT_W-1:0]       inv_two,
  input  logic [CNT_W-1:0]       inv_five,
  input  logic [CNT_W-1:0]       inv_ten,
  change_dispense_ctrl_if.master eject,
  output logic                   busy,
  output logic                   done,
  output logic                   short_change,
  output logic [AMT_W-1:0]       remaining,
  output logic [CNT_W-1:0]       cnt_one,
  output logic [CNT_W-1:0]       cnt_two,
  output logic [CNT_W-1:0]       cnt_five,
  output logic [CNT_W-1:0]       cnt_ten
);

  state_t           state;
  logic [CNT_W-1:0] live_cnt   [4];
  logic [CNT_W-1:0] shadow_cnt [4];
  logic [CNT_W-1:0] inv_vals   [4];
  logic [CNT_W-1:0] cnt_next   [4];
  logic [AMT_W-1:0] plan_rem;
  logic [AMT_W-1:0] pay_val_q;
  logic [3:0]       dep_hit;
  logic [3:0]       dec_hit;
  logic             ack_fire;

  logic             plan_found, pay_found;
  logic [1:0]       plan_sel, pay_sel;
  logic [AMT_W-1:0] plan_val, pay_val;

  assign inv_vals = '{inv_one, inv_two, inv_five, inv_ten};
  assign ack_fire = (state == ST_PAY_WAIT) && eject.eject_ack;

  assign cnt_one  = live_cnt[COIN_ONE];
  assign cnt_two  = live_cnt[COIN_TWO];
  assign cnt_five = live_cnt[COIN_FIVE];
  assign cnt_ten  = live_cnt[COIN_TEN];

  greedy_coin_pick #(.AMT_W(AMT_W), .CNT_W(CNT_W)) u_plan_pick (
    .amount   (plan_rem),
    .cnt_one  (shadow_cnt[COIN_ONE]),
    .cnt_two  (shadow_cnt[COIN_TWO]),
    .cnt_five (shadow_cnt[COIN_FIVE]),
    .cnt_ten  (shadow_cnt[COIN_TEN]),
    .found    (plan_found),
    .coin_sel (plan_sel),
    .coin_val (plan_val)
  );

  greedy_coin_pick #(.AMT_W(AMT_W), .CNT_W(CNT_W)) u_pay_pick (
    .amount   (remaining),
    .cnt_one  (live_cnt[COIN_ONE]),
    .cnt_two  (live_cnt[COIN_TWO]),
    .cnt_five (live_cnt[COIN_FIVE]),
    .cnt_ten  (live_cnt[COIN_TEN]),
    .found    (pay_found),
    .coin_sel (pay_sel),
    .coin_val (pay_val)
  );

  // A deposit and an eject of the same coin in one cycle cancel out; counts saturate.
  always_comb begin
    dep_hit = '0;
    dec_hit = '0;
    if (coin_in_valid) dep_hit[coin_in_sel] = 1'b1;
    if (ack_fire) dec_hit[eject.eject_coin] = 1'b1;
    for (int d = 0; d < 4; d++) begin
      cnt_next[d] = live_cnt[d];
      if (load_inv && state == ST_IDLE) begin
        cnt_next[d] = inv_vals[d];
      end else if (dep_hit[d] && !dec_hit[d]) begin
        if (live_cnt[d] != '1) cnt_next[d] = live_cnt[d] + CNT_W'(1);
      end else if (dec_hit[d] && !dep_hit[d]) begin
        cnt_next[d] = live_cnt[d] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      plan_rem         <= '0;
      pay_val_q        <= '0;
      remaining        <= '0;
      eject.eject_req  <= 1'b0;
      eject.eject_coin <= COIN_ONE;
      busy             <= 1'b0;
      done             <= 1'b0;
      short_change     <= 1'b0;
      for (int d = 0; d < 4; d++) begin
        live_cnt[d]   <= '0;
        shadow_cnt[d] <= '0;
      end
    end else begin
      done         <= 1'b0;
      short_change <= 1'b0;
      for (int d = 0; d < 4; d++) live_cnt[d] <= cnt_next[d];
      case (state)
        ST_IDLE: begin
          if (start) begin
            remaining <= change_amt;
            plan_rem  <= change_amt;
            busy      <= 1'b1;
            for (int d = 0; d < 4; d++) shadow_cnt[d] <= live_cnt[d];
            state <= (change_amt == '0) ? ST_DONE : ST_PLAN;
          end
        end
        ST_PLAN: begin
          if (plan_found) begin
            shadow_cnt[plan_sel] <= shadow_cnt[plan_sel] - CNT_W'(1);
            plan_rem             <= plan_rem - plan_val;
            if (plan_rem == plan_val) state <= ST_PAY_REQ;
          end else begin
            state <= ST_FAIL;
          end
        end
        ST_PAY_REQ: begin
          if (pay_found) begin
            eject.eject_req  <= 1'b1;
            eject.eject_coin <= pay_sel;
            pay_val_q        <= pay_val;
            state            <= ST_PAY_WAIT;
          end else begin
            state <= ST_FAIL;
          end
        end
        ST_PAY_WAIT: begin
          if (eject.eject_ack) begin
            eject.eject_req <= 1'b0;
            remaining       <= remaining - pay_val_q;
            state <= (remaining == pay_val_q) ? ST_DONE : ST_PAY_REQ;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        ST_FAIL: begin
          short_change <= 1'b1;
          busy         <= 1'b0;
          state        <= ST_IDLE;
        end
        default: begin
          eject.eject_req <= 1'b0;
          busy            <= 1'b0;
          state           <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
